mux_cfgchain_sel: RTL

Parametrised routing multiplexer that holds its own configuration: a scan-chain shift register loaded over the configuration chain, plus a shadow (active) register committed atomically, so the selected path never changes while bits are shifting. It sits in the routing fabric (switch and connection blocks) wherever a fixed-size mux primitive is paired with separate configuration flip-flops. It supports one-hot or binary select encoding and flags incomplete or illegal configurations.

---
 rtl/mux_cfgchain_sel.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mux_cfgchain_sel.sv
// Routing multiplexer with its own configuration storage: a serial scan
// chain (sreg) feeds a shadow register (active). Committing copies sreg into
// active in one step, so the selected path never changes while bits shift.
module mux_cfgchain_sel #(
  parameter int  NUM_INPUTS = 8,
  parameter int  ENCODING   = 0,
  localparam int MEM_SIZE   = (ENCODING == 0) ? NUM_INPUTS : $clog2(NUM_INPUTS)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  config_enable,
  input  logic                  ccff_head,
  output logic                  ccff_tail,
  input  logic                  commit,
  input  logic [0:NUM_INPUTS-1] in,
  output logic                  out,
  output logic [0:MEM_SIZE-1]   mem,
  output logic [0:MEM_SIZE-1]   mem_inv,
  output logic                  config_done,
  output logic                  cfg_error
);

  localparam int CNT_W = $clog2(MEM_SIZE + 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } state_t;

  logic [0:MEM_SIZE-1] sreg, sreg_next;
  logic [0:MEM_SIZE-1] active, active_next;
  logic [CNT_W-1:0]    bit_cnt, cnt_next;
  logic                err_next;
  state_t              state;
  logic [7:0]          ones_cnt;
  logic [31:0]         sreg_val;
  logic [31:0]         active_val;
  logic                legal;

  // Configuration state register: chain, shadow copy, shift count, error flag
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sreg      <= '0;
      active    <= '0;
      bit_cnt   <= '0;
      cfg_error <= 1'b0;
    end else begin
      sreg      <= sreg_next;
      active    <= active_next;
      bit_cnt   <= cnt_next;
      cfg_error <= err_next;
    end
  end

  // Load state is derived from how many bits have arrived since the last commit
  always_comb begin
    state = EMPTY;
    if (bit_cnt == CNT_W'(MEM_SIZE)) begin
      state = FULL;
    end else if (bit_cnt != '0) begin
      state = LOADING;
    end
  end

  // Decide whether the pattern waiting in the chain may drive the mux
  always_comb begin
    ones_cnt = 8'd0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (sreg[i]) begin
        ones_cnt = ones_cnt + 8'd1;
      end
    end
    sreg_val = 32'(sreg);
    if (ENCODING == 0) begin
      legal = (ones_cnt == 8'd1);
    end else begin
      legal = (sreg_val < 32'(NUM_INPUTS));
    end
  end

  // Shift has priority over commit; commit only acts on a complete legal load
  always_comb begin
    sreg_next   = sreg;
    active_next = active;
    cnt_next    = bit_cnt;
    err_next    = cfg_error;
    if (config_enable) begin
      sreg_next[0] = ccff_head;
      for (int i = 1; i < MEM_SIZE; i++) begin
        sreg_next[i] = sreg[i-1];
      end
      if (state != FULL) begin
        cnt_next = bit_cnt + CNT_W'(1);
      end
    end else if (commit) begin
      if (state == FULL) begin
        cnt_next = '0;
        if (legal) begin
          active_next = sreg;
          err_next    = 1'b0;
        end else begin
          err_next    = 1'b1;
        end
      end else begin
        err_next = 1'b1;
      end
    end
  end

  // Data path: pick one input using the committed configuration only
  always_comb begin
    out        = 1'b0;
    active_val = 32'(active);
    if (ENCODING == 0) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        out = out | (active[i] & in[i]);
      end
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (active_val == 32'(i)) begin
          out = in[i];
        end
      end
    end
  end

  assign mem         = active;
  assign mem_inv     = ~active;
  assign ccff_tail   = sreg[MEM_SIZE-1];
  assign config_done = (state == FULL);

endmodule
